// File: rtl/fcc_pkg.sv
// Shared constants and helpers for the router flow-control credit logic.
package fcc_pkg;

    localparam int PORT_N           = 0;
    localparam int PORT_S           = 1;
    localparam int PORT_E           = 2;
    localparam int PORT_W           = 3;
    localparam int PORT_L           = 4;
    localparam int NUM_ROUTER_PORTS = 5;
    localparam int FCC_DEFAULT_DEPTH = 4;

    // Counter width able to hold every value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifc_fcc.sv
// Bench-side bundle of the credit-array vector ports.
interface ifc_fcc #(
    parameter int NUM_PORTS = 5,
    parameter int CW        = 3
) (
    input logic clk
);
    logic                    rst_n;
    logic [NUM_PORTS-1:0]    incr;
    logic [NUM_PORTS-1:0]    decr;
    logic                    clear_err;
    logic [NUM_PORTS-1:0]    credit_en;
    logic [NUM_PORTS-1:0]    credit_low;
    logic [NUM_PORTS*CW-1:0] credit_cnt;
    logic [NUM_PORTS-1:0]    ovf_err;
    logic [NUM_PORTS-1:0]    udf_err;

    modport drv (input clk, output rst_n, incr, decr, clear_err,
                 input credit_en, credit_low, credit_cnt, ovf_err, udf_err);
    modport mon (input clk, rst_n, incr, decr, clear_err,
                 credit_en, credit_low, credit_cnt, ovf_err, udf_err);
endinterface

// File: rtl/fcc_credit_counter.sv
// One channel of credit tracking: saturating counter, sticky over/underflow
// flags and the send-enable / low-watermark decode.
module fcc_credit_counter
    import fcc_pkg::*;
#(
    parameter int BUF_DEPTH = FCC_DEFAULT_DEPTH,
    parameter int LOW_WM    = 1,
    parameter int CW        = credit_width(BUF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          incr_i,
    input  logic          decr_i,
    input  logic          clear_err_i,
    output logic [CW-1:0] cnt_o,
    output logic          en_o,
    output logic          low_o,
    output logic          ovf_err_o,
    output logic          udf_err_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] LOW_C   = CW'(LOW_WM);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic [CW-1:0] cnt_d, cnt_q;
    logic          ovf_d, ovf_q;
    logic          udf_d, udf_q;
    logic          ovf_set_s, udf_set_s;

    // Next-state: simultaneous incr+decr cancels, so it is legal at either bound.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
        case ({incr_i, decr_i})
            2'b10: begin
                if (cnt_q < DEPTH_C) begin
                    cnt_d = cnt_q + ONE_C;
                end else begin
                    ovf_set_s = 1'b1;
                end
            end
            2'b01: begin
                if (cnt_q != ZERO_C) begin
                    cnt_d = cnt_q - ONE_C;
                end else begin
                    udf_set_s = 1'b1;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        // A clear wins over an error raised in the same cycle.
        ovf_d = clear_err_i ? 1'b0 : (ovf_q | ovf_set_s);
        udf_d = clear_err_i ? 1'b0 : (udf_q | udf_set_s);
    end

    // State registers with synchronous active-low reset to a full credit pool.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= DEPTH_C;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign en_o      = (cnt_q != ZERO_C);
    assign low_o     = (cnt_q <= LOW_C);
    assign ovf_err_o = ovf_q;
    assign udf_err_o = udf_q;

endmodule

// File: rtl/fcc_credit_array.sv
// Parametrised flow-control credit block: one independent credit counter per
// output channel, with readable counts, low-watermark and sticky error flags.
module fcc_credit_array
    import fcc_pkg::*;
#(
    parameter int NUM_PORTS = NUM_ROUTER_PORTS,
    parameter int BUF_DEPTH = FCC_DEFAULT_DEPTH,
    parameter int LOW_WM    = 1,
    localparam int CW       = credit_width(BUF_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    incr_i,
    input  logic [NUM_PORTS-1:0]    decr_i,
    input  logic                    clear_err_i,
    output logic [NUM_PORTS-1:0]    credit_en_o,
    output logic [NUM_PORTS-1:0]    credit_low_o,
    output logic [NUM_PORTS*CW-1:0] credit_cnt_o,
    output logic [NUM_PORTS-1:0]    ovf_err_o,
    output logic [NUM_PORTS-1:0]    udf_err_o
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ch
        fcc_credit_counter #(
            .BUF_DEPTH (BUF_DEPTH),
            .LOW_WM    (LOW_WM),
            .CW        (CW)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .incr_i      (incr_i[p]),
            .decr_i      (decr_i[p]),
            .clear_err_i (clear_err_i),
            .cnt_o       (credit_cnt_o[p*CW +: CW]),
            .en_o        (credit_en_o[p]),
            .low_o       (credit_low_o[p]),
            .ovf_err_o   (ovf_err_o[p]),
            .udf_err_o   (udf_err_o[p])
        );
    end

endmodule

// File: tb/tb_fcc_credit_array.sv
// Randomised + directed bench for fcc_credit_array with a queue scoreboard
// fed by an arithmetic reference model.
module tb_fcc_credit_array;
    import fcc_pkg::*;

    localparam int NP    = 5;
    localparam int DEPTH = 4;
    localparam int LWM   = 1;
    localparam int CW    = credit_width(DEPTH);

    typedef struct packed {
        logic [NP*CW-1:0] cnt;
        logic [NP-1:0]    en;
        logic [NP-1:0]    low;
        logic [NP-1:0]    ovf;
        logic [NP-1:0]    udf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ifc_fcc #(.NUM_PORTS(NP), .CW(CW)) bus (.clk(clk));

    fcc_credit_array #(.NUM_PORTS(NP), .BUF_DEPTH(DEPTH), .LOW_WM(LWM)) dut (
        .clk          (clk),
        .rst_n        (bus.rst_n),
        .incr_i       (bus.incr),
        .decr_i       (bus.decr),
        .clear_err_i  (bus.clear_err),
        .credit_en_o  (bus.credit_en),
        .credit_low_o (bus.credit_low),
        .credit_cnt_o (bus.credit_cnt),
        .ovf_err_o    (bus.ovf_err),
        .udf_err_o    (bus.udf_err)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    int m_cnt [NP];
    bit m_ovf [NP];
    bit m_udf [NP];

    // Apply one cycle of stimulus and predict the state visible after the next edge.
    task automatic drive(input logic [NP-1:0] inc, input logic [NP-1:0] dec,
                         input logic clr, input logic rstn);
        exp_t e;
        int   nxt;
        @(negedge clk);
        bus.incr      = inc;
        bus.decr      = dec;
        bus.clear_err = clr;
        bus.rst_n     = rstn;
        for (int p = 0; p < NP; p++) begin
            if (!rstn) begin
                m_cnt[p] = DEPTH;
                m_ovf[p] = 1'b0;
                m_udf[p] = 1'b0;
            end else begin
                nxt = m_cnt[p] + int'(inc[p]) - int'(dec[p]);
                if (nxt > DEPTH) begin
                    nxt = DEPTH;
                    m_ovf[p] = 1'b1;
                end
                if (nxt < 0) begin
                    nxt = 0;
                    m_udf[p] = 1'b1;
                end
                m_cnt[p] = nxt;
                if (clr) begin
                    m_ovf[p] = 1'b0;
                    m_udf[p] = 1'b0;
                end
            end
            e.cnt[p*CW +: CW] = CW'(m_cnt[p]);
            e.en[p]  = (m_cnt[p] != 0);
            e.low[p] = (m_cnt[p] <= LWM);
            e.ovf[p] = m_ovf[p];
            e.udf[p] = m_udf[p];
        end
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: every edge presents a new state, compared against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            cmp("credit_cnt", 32'(bus.credit_cnt), 32'(e.cnt));
            cmp("credit_en",  32'(bus.credit_en),  32'(e.en));
            cmp("credit_low", 32'(bus.credit_low), 32'(e.low));
            cmp("ovf_err",    32'(bus.ovf_err),    32'(e.ovf));
            cmp("udf_err",    32'(bus.udf_err),    32'(e.udf));
        end
    end

    initial begin
        bus.rst_n     = 1'b0;
        bus.incr      = '0;
        bus.decr      = '0;
        bus.clear_err = 1'b0;
        for (int p = 0; p < NP; p++) begin
            m_cnt[p] = DEPTH;
            m_ovf[p] = 1'b0;
            m_udf[p] = 1'b0;
        end

        // Reset, then drain channel 0.
        repeat (2) drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        drive(5'b00000, 5'b00000, 1'b0, 1'b1);
        repeat (4) drive(5'b00000, 5'b00001, 1'b0, 1'b1);

        // Channel 2: incr+decr held at both bounds.
        repeat (4) drive(5'b00000, 5'b00100, 1'b0, 1'b1);
        repeat (3) drive(5'b00100, 5'b00100, 1'b0, 1'b1);
        repeat (4) drive(5'b00100, 5'b00000, 1'b0, 1'b1);
        drive(5'b00100, 5'b00100, 1'b0, 1'b1);

        // Channel 1 underflow, recovery, clear.
        repeat (4) drive(5'b00000, 5'b00010, 1'b0, 1'b1);
        drive(5'b00000, 5'b00010, 1'b0, 1'b1);
        drive(5'b00000, 5'b00000, 1'b0, 1'b1);
        drive(5'b00010, 5'b00000, 1'b0, 1'b1);
        drive(5'b00000, 5'b00000, 1'b1, 1'b1);
        drive(5'b00000, 5'b00000, 1'b0, 1'b1);

        // Channel 4 overflow.
        drive(5'b10000, 5'b00000, 1'b0, 1'b1);
        drive(5'b00000, 5'b00000, 1'b0, 1'b1);

        // Clear wins over a same-cycle underflow on channel 3.
        repeat (4) drive(5'b00000, 5'b01000, 1'b0, 1'b1);
        drive(5'b00000, 5'b01000, 1'b1, 1'b1);
        drive(5'b00000, 5'b00000, 1'b0, 1'b1);

        // Counts {0,1,2,3,4} with errors, then reset alongside decr on all.
        drive(5'b00000, 5'b00000, 1'b0, 1'b0);
        drive(5'b00000, 5'b01111, 1'b0, 1'b1);
        drive(5'b00000, 5'b00111, 1'b0, 1'b1);
        drive(5'b00000, 5'b00011, 1'b0, 1'b1);
        drive(5'b00000, 5'b00001, 1'b0, 1'b1);
        drive(5'b10000, 5'b00001, 1'b0, 1'b1);
        drive(5'b00000, 5'b11111, 1'b0, 1'b0);
        drive(5'b00000, 5'b00000, 1'b0, 1'b1);

        // Random walk that regularly reaches both bounds.
        for (int i = 0; i < 1500; i++) begin
            drive(NP'($urandom), NP'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
        end

        @(negedge clk);
        bus.incr = '0;
        bus.decr = '0;
        @(posedge clk);
        #4;
        cmp("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
